// File: rtl/dffen_wr_arb_if.sv
// Write-request bus between N requesters and the shared dffen arbiter.
interface dffen_wr_arb_if #(
  parameter int unsigned N = 4,
  parameter int unsigned W = 32
);
  localparam int unsigned IDW = $clog2(N);

  logic [N-1:0]   req_vld_i;
  logic [N*W-1:0] req_data_i;
  logic [N-1:0]   req_rdy_o;
  logic           en_o;
  logic [W-1:0]   d_o;
  logic [IDW-1:0] gnt_id_o;
  logic           busy_o;

  // Requester / register side
  modport master (
    output req_vld_i, req_data_i,
    input  req_rdy_o, en_o, d_o, gnt_id_o, busy_o
  );

  // Arbiter side
  modport slave (
    input  req_vld_i, req_data_i,
    output req_rdy_o, en_o, d_o, gnt_id_o, busy_o
  );
endinterface

// File: rtl/dffen_wr_arb.sv
// Round-robin write arbiter with burst lock in front of a shared dffen.
// A winner keeps the grant for up to BURST beats; every lock ends with one
// release cycle (no write) before the pointer moves past the owner.
module dffen_wr_arb #(
  parameter int unsigned N     = 4,
  parameter int unsigned W     = 32,
  parameter int unsigned BURST = 4
) (
  input  logic           clk,
  input  logic           arst_n,
  dffen_wr_arb_if.slave  bus
);

  localparam int unsigned IDW = $clog2(N);
  localparam int unsigned CW  = $clog2(BURST) + 1;

  typedef enum logic {
    ST_ARB  = 1'b0,
    ST_LOCK = 1'b1
  } state_e;

  state_e         state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [IDW-1:0] owner_q, owner_d;
  logic [CW-1:0]  cnt_q, cnt_d;

  logic           win_vld;
  logic [IDW-1:0] win_idx;
  logic [N-1:0]   rdy_c;
  logic [IDW-1:0] acc_idx;
  logic           acc;
  logic [W-1:0]   d_sel;

  // Increment an index with wrap N-1 -> 0
  function automatic logic [IDW-1:0] next_idx(input logic [IDW-1:0] i);
    if (32'(i) == N - 1) return '0;
    return i + IDW'(1);
  endfunction

  // First valid requester searching ptr, ptr+1, ... mod N
  always_comb begin
    int unsigned    j;
    logic [IDW-1:0] jj;
    win_vld = 1'b0;
    win_idx = '0;
    j       = 0;
    jj      = '0;
    for (int unsigned k = 0; k < N; k++) begin
      j = 32'(ptr_q) + k;
      if (j >= N) j = j - N;
      jj = IDW'(j);
      if (!win_vld && bus.req_vld_i[jj]) begin
        win_vld = 1'b1;
        win_idx = jj;
      end
    end
  end

  // Ready generation; all rdy forced low while reset is asserted
  always_comb begin
    rdy_c   = '0;
    acc_idx = win_idx;
    if (arst_n) begin
      unique case (state_q)
        ST_ARB: begin
          if (win_vld) rdy_c[win_idx] = 1'b1;
        end
        ST_LOCK: begin
          acc_idx = owner_q;
          if (cnt_q != CW'(BURST)) rdy_c[owner_q] = 1'b1;
        end
        default: rdy_c = '0;
      endcase
    end
  end

  assign acc = |(rdy_c & bus.req_vld_i);

  // Select the accepted writer's data slice
  always_comb begin
    d_sel = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (acc_idx == IDW'(i)) d_sel = bus.req_data_i[i*W +: W];
    end
  end

  assign bus.req_rdy_o = rdy_c;
  assign bus.en_o      = acc;
  assign bus.d_o       = acc ? d_sel : '0;
  assign bus.gnt_id_o  = acc ? acc_idx : '0;
  assign bus.busy_o    = (state_q == ST_LOCK);

  // Next-state: ARB grants and opens a lock, LOCK counts beats then releases
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_ARB: begin
        if (win_vld) begin
          if (BURST == 1) begin
            ptr_d = next_idx(win_idx);
          end else begin
            state_d = ST_LOCK;
            owner_d = win_idx;
            cnt_d   = CW'(1);
          end
        end
      end
      ST_LOCK: begin
        if (cnt_q != CW'(BURST) && bus.req_vld_i[owner_q]) begin
          cnt_d = cnt_q + CW'(1);
        end else begin
          state_d = ST_ARB;
          ptr_d   = next_idx(owner_q);
          cnt_d   = '0;
        end
      end
      default: state_d = ST_ARB;
    endcase
  end

  // State registers
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q <= ST_ARB;
      ptr_q   <= '0;
      owner_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_dffen_wr_arb.sv
// Self-checking bench for dffen_wr_arb: directed scenarios plus random traffic
// compared every cycle against a behavioural model of the arbiter.
module tb_dffen_wr_arb;

  localparam int unsigned N     = 4;
  localparam int unsigned W     = 32;
  localparam int unsigned BURST = 4;

  logic clk;
  logic arst_n;

  dffen_wr_arb_if #(.N(N), .W(W)) bus ();

  dffen_wr_arb #(.N(N), .W(W), .BURST(BURST)) dut (
    .clk    (clk),
    .arst_n (arst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests;
  int n_fail;

  // Model: owner keeps grant for BURST beats, then one idle release cycle
  bit          m_lock;
  int          m_ptr;
  int          m_owner;
  int          m_beats;

  logic [W-1:0]   td [N];
  logic [N-1:0]   cur_vld;

  logic [N-1:0]   obs_rdy;
  logic           obs_en;
  logic [W-1:0]   obs_d;
  logic [1:0]     obs_gnt;
  logic           obs_busy;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: drive at posedge+1, compare at negedge, advance model
  task automatic cycle(input logic [N-1:0] vld, input logic rstn);
    logic [N*W-1:0] pack;
    logic [N-1:0]   e_rdy;
    logic           e_en;
    logic           e_busy;
    int             e_id;
    int             w;
    bit             found;

    pack = '0;
    for (int i = 0; i < N; i++) begin
      td[i] = $urandom;
      pack[i*W +: W] = td[i];
    end
    cur_vld        = vld;
    bus.req_vld_i  = vld;
    bus.req_data_i = pack;
    arst_n         = rstn;

    @(negedge clk);
    e_rdy  = '0;
    e_busy = 1'b0;
    found  = 1'b0;
    w      = 0;
    if (arst_n) begin
      if (!m_lock) begin
        for (int k = 0; k < N; k++) begin
          if (!found && vld[(m_ptr + k) % N]) begin
            found = 1'b1;
            w     = (m_ptr + k) % N;
          end
        end
        if (found) e_rdy[w] = 1'b1;
      end else begin
        e_busy = 1'b1;
        if (m_beats < BURST) e_rdy[m_owner] = 1'b1;
      end
    end
    e_en = |(e_rdy & vld);
    e_id = 0;
    for (int i = 0; i < N; i++) if (e_rdy[i] && e_en) e_id = i;

    obs_rdy  = bus.req_rdy_o;
    obs_en   = bus.en_o;
    obs_d    = bus.d_o;
    obs_gnt  = bus.gnt_id_o;
    obs_busy = bus.busy_o;

    chk("en_known", 64'($isunknown(bus.en_o)), 64'd0);
    chk("rdy",  64'(obs_rdy),  64'(e_rdy));
    chk("en",   64'(obs_en),   64'(e_en));
    chk("d",    64'(obs_d),    e_en ? 64'(td[e_id]) : 64'd0);
    chk("gnt",  64'(obs_gnt),  64'(e_id));
    chk("busy", 64'(obs_busy), 64'(e_busy));

    if (!arst_n) begin
      m_lock = 1'b0; m_ptr = 0; m_owner = 0; m_beats = 0;
    end else if (!m_lock) begin
      if (found) begin
        if (BURST == 1) m_ptr = (w + 1) % N;
        else begin m_lock = 1'b1; m_owner = w; m_beats = 1; end
      end
    end else if (m_beats < BURST && vld[m_owner]) begin
      m_beats++;
    end else begin
      m_lock = 1'b0;
      m_ptr  = (m_owner + 1) % N;
    end

    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    cycle('0, 1'b0);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    m_lock = 1'b0; m_ptr = 0; m_owner = 0; m_beats = 0;
    arst_n         = 1'b0;
    bus.req_vld_i  = '0;
    bus.req_data_i = '0;
    @(posedge clk);
    #1;

    // 1: reset holds outputs low with all valid, then req0 wins
    cycle(4'b1111, 1'b0);
    cycle(4'b1111, 1'b0);
    chk("t1_rst_en",   64'(obs_en),   64'd0);
    chk("t1_rst_rdy",  64'(obs_rdy),  64'd0);
    chk("t1_rst_busy", 64'(obs_busy), 64'd0);
    cycle(4'b1111, 1'b1);
    chk("t1_first_en",  64'(obs_en),  64'd1);
    chk("t1_first_gnt", 64'(obs_gnt), 64'd0);

    // 2: single requester: 4 beats, bubble, new grant
    do_reset();
    for (int c = 0; c < 6; c++) begin
      cycle(4'b0100, 1'b1);
      chk("t2_en",   64'(obs_en),   (c == 4) ? 64'd0 : 64'd1);
      chk("t2_busy", 64'(obs_busy), (c == 0 || c == 5) ? 64'd0 : 64'd1);
      if (c != 4) chk("t2_gnt", 64'(obs_gnt), 64'd2);
    end

    // 3: all valid: 4 beats per owner, one bubble between owners, wrap to 0
    do_reset();
    for (int c = 0; c < 24; c++) begin
      cycle(4'b1111, 1'b1);
      chk("t3_en", 64'(obs_en), (c % 5 == 4) ? 64'd0 : 64'd1);
      if (c % 5 != 4) chk("t3_gnt", 64'(obs_gnt), 64'((c / 5) % 4));
    end

    // 4: early release of id1 after two beats, next grant goes to id2
    do_reset();
    cycle(4'b0010, 1'b1);
    chk("t4_b1", 64'(obs_gnt), 64'd1);
    cycle(4'b0010, 1'b1);
    chk("t4_b2", 64'(obs_en), 64'd1);
    cycle(4'b0101, 1'b1);
    chk("t4_bubble", 64'(obs_en), 64'd0);
    cycle(4'b0101, 1'b1);
    chk("t4_next_en",  64'(obs_en),  64'd1);
    chk("t4_next_gnt", 64'(obs_gnt), 64'd2);

    // 5: lock exclusion for owner 3 while id0 also valid
    do_reset();
    cycle(4'b1000, 1'b1);
    chk("t5_gnt", 64'(obs_gnt), 64'd3);
    cycle(4'b1001, 1'b1);
    chk("t5_rdy", 64'(obs_rdy), 64'b1000);
    chk("t5_d",   64'(obs_d),   64'(td[3]));

    // 6: reset mid-burst abandons the lock; lowest valid index wins after
    do_reset();
    cycle(4'b0100, 1'b1);
    cycle(4'b0100, 1'b1);
    cycle(4'b0100, 1'b0);
    chk("t6_rst_en",   64'(obs_en),   64'd0);
    chk("t6_rst_busy", 64'(obs_busy), 64'd0);
    cycle(4'b0110, 1'b1);
    chk("t6_after_gnt", 64'(obs_gnt), 64'd1);

    // Random traffic with occasional resets
    for (int c = 0; c < 3000; c++) begin
      logic [N-1:0] v;
      v = ($urandom_range(0, 3) == 0) ? N'($urandom) : cur_vld | N'($urandom & $urandom);
      if ($urandom_range(0, 7) == 0) v = N'($urandom);
      cycle(v, ($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
